// File: rtl/ft_cmd_regfile.sv
// rtl/ft_cmd_regfile.sv - host command decoder driving a register file with acks/read-back into cpucmd_fifo
// Optional build macro CMD_TIMEOUT_EN adds an idle timeout inside WRITE payloads.
module ft_cmd_regfile #(
    parameter int FT_DATA_WIDTH  = 32,
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [FT_DATA_WIDTH-1:0]     cmd_data_i,
    input  logic                         cmd_we_i,
    output logic                         busy_o,
    output logic [FT_DATA_WIDTH-1:0]     fifo_data_o,
    output logic                         fifo_we_o,
    input  logic                         fifo_full_i,
    output logic [NUM_REGS*32-1:0]       regs_o,
    output logic [7:0]                   drop_cnt_o
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_ACK, RD_HDR, RD_DATA, ERR} state_t;

    state_t                 state, state_nx;
    logic [31:0]            regs [NUM_REGS];
    logic [7:0]             hdr_addr;
    logic [15:0]            hdr_cnt;
    logic [AW-1:0]          ptr;
    logic [15:0]            rem;
    logic [31:0]            err_word;
    logic [31:0]            emit_word;
    logic                   fire;
    logic                   hdr_bad;
    logic                   timeout_hit;

    assign hdr_bad = !(cmd_data_i[31:24] == 8'hA1 || cmd_data_i[31:24] == 8'hA2)
                   || ({1'b0, cmd_data_i[23:16]} >= 9'(NUM_REGS));

    assign busy_o = (state == WR_ACK) || (state == RD_HDR) || (state == RD_DATA) || (state == ERR);
    assign fire   = busy_o && !fifo_full_i;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    assign timeout_hit = !cmd_we_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        emit_word = err_word;
        case (state)
            WR_ACK:  emit_word = {8'hA1, hdr_addr, hdr_cnt};
            RD_HDR:  emit_word = {8'hA2, hdr_addr, hdr_cnt};
            RD_DATA: emit_word = regs[ptr];
            default: emit_word = err_word;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_we_i) begin
                if (hdr_bad)                        state_nx = ERR;
                else if (cmd_data_i[31:24] == 8'hA2) state_nx = RD_HDR;
                else if (cmd_data_i[15:0] != 16'd0) state_nx = WR_DATA;
                else                                state_nx = WR_ACK;
            end
            WR_DATA: begin
                if (cmd_we_i && rem == 16'd1) state_nx = WR_ACK;
                else if (timeout_hit)         state_nx = ERR;
            end
            WR_ACK:  if (fire) state_nx = IDLE;
            RD_HDR:  if (fire) state_nx = (hdr_cnt == 16'd0) ? IDLE : RD_DATA;
            RD_DATA: if (fire && rem == 16'd1) state_nx = IDLE;
            ERR:     if (fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= 32'd0;
            hdr_addr    <= 8'd0;
            hdr_cnt     <= 16'd0;
            ptr         <= '0;
            rem         <= 16'd0;
            err_word    <= 32'd0;
            fifo_we_o   <= 1'b0;
            fifo_data_o <= '0;
            drop_cnt_o  <= 8'd0;
`ifdef CMD_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            fifo_we_o <= fire;
            if (fire) fifo_data_o <= emit_word;
            if (busy_o && cmd_we_i && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;

            case (state)
                IDLE: if (cmd_we_i) begin
                    hdr_addr <= cmd_data_i[23:16];
                    hdr_cnt  <= cmd_data_i[15:0];
                    ptr      <= cmd_data_i[16 +: AW];
                    rem      <= cmd_data_i[15:0];
                    err_word <= {8'hEE, cmd_data_i[31:24], cmd_data_i[23:16], 8'h00};
`ifdef CMD_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                end
                WR_DATA: begin
                    if (cmd_we_i) begin
                        regs[ptr] <= cmd_data_i;
                        ptr       <= ptr + 1'b1;
                        rem       <= rem - 16'd1;
                    end
`ifdef CMD_TIMEOUT_EN
                    if (cmd_we_i) idle_cnt <= '0;
                    else          idle_cnt <= idle_cnt + 1'b1;
`endif
                    // Timeout reports the words still outstanding
                    if (timeout_hit) err_word <= {8'hEF, hdr_addr, rem};
                end
                RD_DATA: if (fire) begin
                    ptr <= ptr + 1'b1;
                    rem <= rem - 16'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[32*k +: 32] = regs[k];
    end
endmodule

// File: tb/tb_ft_cmd_regfile.sv
// tb/tb_ft_cmd_regfile.sv - scoreboard bench for ft_cmd_regfile
module tb_ft_cmd_regfile;
`ifdef CMD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int NR = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       cmd_data_i = '0;
    logic              cmd_we_i = 1'b0;
    logic              busy_o;
    logic [31:0]       fifo_data_o;
    logic              fifo_we_o;
    logic              fifo_full_i = 1'b0;
    logic [NR*32-1:0]  regs_o;
    logic [7:0]        drop_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];
    logic full_s = 1'b0;

    ft_cmd_regfile #(.FT_DATA_WIDTH(32), .NUM_REGS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_data_i(cmd_data_i), .cmd_we_i(cmd_we_i),
        .busy_o(busy_o), .fifo_data_o(fifo_data_o), .fifo_we_o(fifo_we_o),
        .fifo_full_i(fifo_full_i), .regs_o(regs_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) full_s <= fifo_full_i;

    // Monitor: every fifo write must match the head of the expected queue
    always @(negedge clk) begin
        if (fifo_we_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_fifo_word got=%08h expected=none", fifo_data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (fifo_data_o !== e) begin
                    n_bad++;
                    $display("FAIL fifo_word got=%08h expected=%08h", fifo_data_o, e);
                end
            end
            n_cmp++;
            if (full_s) begin
                n_bad++;
                $display("FAIL write_while_full got=we1 expected=we0");
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        cmd_data_i = w;
        cmd_we_i   = 1'b1;
        @(posedge clk); #1;
        cmd_we_i   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (t >= 300) begin
            n_bad++;
            $display("FAIL %s_timeout got=%0d_pending expected=0_pending", name, exp_q.size());
        end
    endtask

    function automatic logic [31:0] reg_at(input int k);
        return regs_o[32*k +: 32];
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg3", reg_at(3), 32'h0);
        check("rst_fifo_we", {31'd0, fifo_we_o}, 32'h0);
        check("rst_fifo_data", fifo_data_o, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'h0);
        check("rst_drop", {24'd0, drop_cnt_o}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        exp_q.push_back(32'hA1030002);
        send(32'hA1030002); send(32'h11111111); send(32'h22222222);
        wait_idle("write3");
        check("reg3", reg_at(3), 32'h11111111);
        check("reg4", reg_at(4), 32'h22222222);

        exp_q.push_back(32'hA10F0002);
        send(32'hA10F0002); send(32'hAAAA0001); send(32'hBBBB0002);
        wait_idle("write_wrap");
        check("reg15", reg_at(15), 32'hAAAA0001);
        check("reg0", reg_at(0), 32'hBBBB0002);
        exp_q.push_back(32'hA20F0002);
        exp_q.push_back(32'hAAAA0001);
        exp_q.push_back(32'hBBBB0002);
        send(32'hA20F0002);
        wait_idle("read_wrap");

        exp_q.push_back(32'hEE550000);
        send(32'h55000000);
        wait_idle("bad_op");
        exp_q.push_back(32'hEEA12000);
        send(32'hA1200000);
        wait_idle("bad_addr");
        check("busy_after_err", {31'd0, busy_o}, 32'h0);

        // Latency: zero-count WRITE header in N, ack in N+2
        exp_q.push_back(32'hA1050000);
        send(32'hA1050000);
        @(negedge clk);
        check("lat_n1_we", {31'd0, fifo_we_o}, 32'h0);
        @(negedge clk);
        check("lat_n2_we", {31'd0, fifo_we_o}, 32'h1);
        wait_idle("lat");

        fifo_full_i = 1'b1;
        exp_q.push_back(32'hA2000004);
        exp_q.push_back(32'hBBBB0002);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h11111111);
        send(32'hA2000004);
        send(32'hDEAD0001); send(32'hDEAD0002); send(32'hDEAD0003);
        repeat (7) @(posedge clk);
        #1;
        check("full_pending", exp_q.size(), 32'd5);
        fifo_full_i = 1'b0;
        wait_idle("read_full");
        check("drop_cnt", {24'd0, drop_cnt_o}, 32'd3);

        send(32'hA1060003); send(32'h12345678);
        @(negedge clk);
        check("pre_rst_reg6", reg_at(6), 32'h12345678);
        reset_n = 1'b0;
        #2;
        check("mid_rst_reg6", reg_at(6), 32'h0);
        check("mid_rst_reg3", reg_at(3), 32'h0);
        check("mid_rst_drop", {24'd0, drop_cnt_o}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(32'hA2060001);
        exp_q.push_back(32'h0);
        send(32'hA2060001);
        wait_idle("post_rst_read");

`ifdef CMD_TIMEOUT_EN
        exp_q.push_back(32'hEF020002);
        send(32'hA1020003); send(32'h0BADF00D);
        wait_idle("timeout");
        check("to_reg2", reg_at(2), 32'h0BADF00D);
`endif

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
